// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the core's load/store port.
// Accepts one request at a time over valid/ready, holds it for the configured
// wait states, performs an RV32 byte/half/word load or store against local
// storage, and presents the result on a valid/ready response channel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | req_ready high, waiting for a request
// WAIT    | request latched, wait states counting, access on last one
// RESP    | response held on rsp_* until rsp_ready
module dmem_responder #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int WORDS = 2 ** (DM_ADDRESS - 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // The access happens on the final WAIT cycle; WAIT lasts WAIT_CYCLES+1
  // cycles so that rsp_valid rises WAIT_CYCLES+1 edges after acceptance.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  logic [1:0]            state;
  logic [3:0]            wait_cnt;

  logic                  lat_write;
  logic [DM_ADDRESS-1:0] lat_addr;
  logic [DATA_W-1:0]     lat_wdata;
  logic [2:0]            lat_funct3;

  logic [DATA_W-1:0]     mem [WORDS];

  logic [DM_ADDRESS-3:0] word_idx;
  logic [1:0]            lane;
  logic [DATA_W-1:0]     cur_word;
  logic [DATA_W-1:0]     store_word;
  logic [DATA_W-1:0]     load_data;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  access_now;
  logic                  acc_err;
  logic                  mem_we;

  assign word_idx   = lat_addr[DM_ADDRESS-1:2];
  assign lane       = lat_addr[1:0];
  assign cur_word   = mem[word_idx];
  assign byte_sel   = cur_word[{lane, 3'b000} +: 8];
  assign half_sel   = cur_word[{lane[1], 4'b0000} +: 16];

  assign access_now = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);
  assign mem_we     = access_now && lat_write && !acc_err;

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

  // Misalignment and illegal funct3 detection on the latched request.
  always_comb begin
    acc_err = 1'b0;
    case (lat_funct3)
      3'd0, 3'd4: acc_err = 1'b0;
      3'd1, 3'd5: acc_err = lane[0];
      3'd2:       acc_err = |lane;
      default:    acc_err = 1'b1;
    endcase
  end

  // Merge store data into the addressed word; untouched lanes keep old bytes.
  always_comb begin
    store_word = cur_word;
    case (lat_funct3[1:0])
      2'd0:    store_word[{lane, 3'b000} +: 8]     = lat_wdata[7:0];
      2'd1:    store_word[{lane[1], 4'b0000} +: 16] = lat_wdata[15:0];
      default: store_word = lat_wdata;
    endcase
  end

  // Lane select and sign/zero extension for loads.
  always_comb begin
    load_data = '0;
    case (lat_funct3)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_data = cur_word;
      3'd4:    load_data = {24'd0, byte_sel};
      3'd5:    load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_idx] <= store_word;
    end
  end

  // Request latch, wait counter, FSM and registered response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
            wait_cnt   <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (access_now) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (lat_write || acc_err) ? '0 : load_data;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (two wait settings) driven with
// directed and random load/store traffic against a byte-array memory model.
module tb_dmem_responder;

  logic        clk;
  logic [1:0]  reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [8:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata  [2];
  logic [1:0]  rsp_err;
  logic [1:0]  busy;

  int n_checks = 0;
  int n_fail   = 0;
  int wc [2]   = '{2, 0};

  logic [7:0] model_mem [2][512];

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset_n(reset_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset_n(reset_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [2:0] f3, input logic [8:0] a);
    int ai;
    ai = int'(a);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (ai % 2) != 0;
      3'd2:       return (ai % 4) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int u, input logic [2:0] f3, input logic [8:0] a);
    int ai;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    ai = int'(a);
    b = model_mem[u][ai];
    h = {model_mem[u][(ai + 1) % 512], model_mem[u][ai]};
    w = {model_mem[u][(ai + 3) % 512], model_mem[u][(ai + 2) % 512], h};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return w;
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_store(input int u, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d);
    int n;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      model_mem[u][(int'(a) + i) % 512] = d[8*i +: 8];
    end
  endtask

  task automatic drive_accept(input int u, input bit wr, input logic [8:0] a,
                              input logic [31:0] d, input logic [2:0] f3, input string tag);
    int guard;
    @(negedge clk);
    req_write[u]  = wr;
    req_addr[u]   = a;
    req_wdata[u]  = d;
    req_funct3[u] = f3;
    req_valid[u]  = 1'b1;
    guard = 0;
    while (!req_ready[u] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_val({tag, " req_ready"}, 32'(req_ready[u]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[u]  = 1'b0;
    req_write[u]  = 1'($urandom);
    req_addr[u]   = 9'($urandom);
    req_wdata[u]  = $urandom;
    req_funct3[u] = 3'($urandom);
  endtask

  task automatic txn(input int u, input bit wr, input logic [8:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input int hold, input bit early, input string tag);
    bit          exp_err;
    logic [31:0] exp_data;
    int          lat;
    exp_err  = model_err(f3, a);
    exp_data = (wr || exp_err) ? 32'd0 : model_load(u, f3, a);
    drive_accept(u, wr, a, d, f3, tag);
    rsp_ready[u] = early;
    lat = 0;
    while (!rsp_valid[u] && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_val({tag, " latency"}, 32'(lat), 32'(wc[u] + 1));
    check_val({tag, " busy"}, 32'(busy[u]), 32'd1);
    check_val({tag, " ready_in_resp"}, 32'(req_ready[u]), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, " hold_valid"}, 32'(rsp_valid[u]), 32'd1);
      check_val({tag, " hold_rdata"}, rsp_rdata[u], exp_data);
      check_val({tag, " hold_ready"}, 32'(req_ready[u]), 32'd0);
    end
    rsp_ready[u] = 1'b1;
    check_val({tag, " rdata"}, rsp_rdata[u], exp_data);
    check_val({tag, " err"}, 32'(rsp_err[u]), 32'(exp_err));
    @(posedge clk);
    @(negedge clk);
    rsp_ready[u] = 1'b0;
    check_val({tag, " valid_drop"}, 32'(rsp_valid[u]), 32'd0);
    check_val({tag, " ready_back"}, 32'(req_ready[u]), 32'd1);
    if (wr && !exp_err) model_store(u, f3, a, d);
  endtask

  task automatic check_reset_outputs(input int u, input string tag);
    check_val({tag, " rst_valid"}, 32'(rsp_valid[u]), 32'd0);
    check_val({tag, " rst_ready"}, 32'(req_ready[u]), 32'd1);
    check_val({tag, " rst_busy"}, 32'(busy[u]), 32'd0);
    check_val({tag, " rst_rdata"}, rsp_rdata[u], 32'd0);
    check_val({tag, " rst_err"}, 32'(rsp_err[u]), 32'd0);
  endtask

  // Store word, then reset mid-WAIT (dropped) or mid-RESP (committed).
  task automatic txn_reset(input int u, input logic [8:0] a, input logic [31:0] d,
                           input bit in_resp, input string tag);
    int guard;
    drive_accept(u, 1'b1, a, d, 3'd2, tag);
    if (in_resp) begin
      guard = 0;
      while (!rsp_valid[u] && guard < 50) begin
        @(posedge clk);
        guard++;
        @(negedge clk);
      end
      check_val({tag, " reached_resp"}, 32'(rsp_valid[u]), 32'd1);
    end
    reset_n[u] = 1'b0;
    #1;
    check_reset_outputs(u, tag);
    @(negedge clk);
    reset_n[u] = 1'b1;
    if (in_resp) model_store(u, 3'd2, a, d);
  endtask

  task automatic random_txn(input int u);
    logic [2:0] f3;
    logic [8:0] a;
    bit         wr;
    int         pick;
    int         hold;
    bit         early;
    pick = $urandom_range(0, 9);
    case (pick)
      0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
      4: f3 = 3'd5; 5: f3 = 3'd3; 6: f3 = 3'd6; 7: f3 = 3'd7;
      default: f3 = 3'd2;
    endcase
    wr = 1'($urandom);
    if (f3 == 3'd4 || f3 == 3'd5) wr = 1'b0;
    a = 9'($urandom);
    if ($urandom_range(0, 3) != 0) begin
      if (f3[1:0] == 2'd1) a[0] = 1'b0;
      if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
    end
    hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    early = (hold == 0) && ($urandom_range(0, 3) == 0);
    txn(u, wr, a, $urandom, f3, hold, early, "rand");
  endtask

  initial begin
    reset_n   = 2'b00;
    req_valid = 2'b00;
    req_write = 2'b00;
    rsp_ready = 2'b00;
    for (int u = 0; u < 2; u++) begin
      req_addr[u]   = '0;
      req_wdata[u]  = '0;
      req_funct3[u] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "init0");
    check_reset_outputs(1, "init1");
    reset_n = 2'b11;

    for (int u = 0; u < 2; u++) begin
      for (int w = 0; w < 128; w++) begin
        txn(u, 1'b1, 9'(w * 4), $urandom, 3'd2, 0, 1'b0, "fill");
      end
    end

    txn(0, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2, 0, 1'b0, "t1_sw");
    txn(0, 1'b0, 9'h010, 32'h0,        3'd2, 0, 1'b0, "t1_lw");
    check_val("t1_value", rsp_rdata[0], 32'hDEADBEEF);

    txn(0, 1'b1, 9'h010, 32'h11223344, 3'd2, 0, 1'b0, "t2_sw");
    txn(0, 1'b1, 9'h013, 32'h000000A5, 3'd0, 0, 1'b0, "t2_sb");
    txn(0, 1'b0, 9'h013, 32'h0,        3'd0, 0, 1'b0, "t2_lb");
    check_val("t2_lb_value", rsp_rdata[0], 32'hFFFFFFA5);
    txn(0, 1'b0, 9'h013, 32'h0,        3'd4, 0, 1'b0, "t2_lbu");
    check_val("t2_lbu_value", rsp_rdata[0], 32'h000000A5);
    txn(0, 1'b0, 9'h010, 32'h0,        3'd2, 0, 1'b0, "t2_lw");
    check_val("t2_lw_value", rsp_rdata[0], 32'hA5223344);

    txn(0, 1'b1, 9'h020, 32'hCAFEBABE, 3'd2, 0, 1'b0, "t3_sw");
    txn(0, 1'b1, 9'h022, 32'h00008001, 3'd1, 0, 1'b0, "t3_sh");
    txn(0, 1'b0, 9'h022, 32'h0,        3'd1, 0, 1'b0, "t3_lh");
    check_val("t3_lh_value", rsp_rdata[0], 32'hFFFF8001);
    txn(0, 1'b0, 9'h022, 32'h0,        3'd5, 0, 1'b0, "t3_lhu");
    check_val("t3_lhu_value", rsp_rdata[0], 32'h00008001);
    txn(0, 1'b0, 9'h020, 32'h0,        3'd2, 0, 1'b0, "t3_lw");
    check_val("t3_lw_value", rsp_rdata[0], 32'h8001BABE);

    txn(0, 1'b0, 9'h012, 32'h0,        3'd2, 0, 1'b0, "t4_lw_mis");
    check_val("t4_lw_mis_err", 32'(rsp_err[0]), 32'd1);
    txn(0, 1'b1, 9'h021, 32'h0000FFFF, 3'd1, 0, 1'b0, "t4_sh_mis");
    check_val("t4_sh_mis_err", 32'(rsp_err[0]), 32'd1);
    txn(0, 1'b0, 9'h020, 32'h0,        3'd2, 0, 1'b0, "t4_lw");
    check_val("t4_lw_value", rsp_rdata[0], 32'h8001BABE);
    txn(0, 1'b0, 9'h020, 32'h0,        3'd3, 0, 1'b0, "t4_f3_3");
    txn(0, 1'b1, 9'h020, 32'h0,        3'd7, 0, 1'b0, "t4_f3_7");

    txn(0, 1'b0, 9'h010, 32'h0,        3'd2, 5, 1'b0, "t5_hold");
    txn(1, 1'b0, 9'h010, 32'h0,        3'd2, 5, 1'b0, "t5_hold1");
    txn(0, 1'b0, 9'h013, 32'h0,        3'd0, 0, 1'b1, "t5_early");

    txn(0, 1'b1, 9'h030, 32'hA0A0A0A0, 3'd2, 0, 1'b0, "t6_pre");
    txn_reset(0, 9'h030, 32'h12345678, 1'b0, "t6_rst_wait");
    txn(0, 1'b0, 9'h030, 32'h0,        3'd2, 0, 1'b0, "t6_lw");
    check_val("t6_lw_value", rsp_rdata[0], 32'hA0A0A0A0);
    txn(1, 1'b1, 9'h030, 32'hB0B0B0B0, 3'd2, 0, 1'b0, "t6_pre1");
    txn_reset(1, 9'h030, 32'h12345678, 1'b0, "t6_rst_wait1");
    txn(1, 1'b0, 9'h030, 32'h0,        3'd2, 0, 1'b0, "t6_lw1");
    check_val("t6_lw1_value", rsp_rdata[1], 32'hB0B0B0B0);
    txn_reset(0, 9'h034, 32'h87654321, 1'b1, "t6_rst_resp");
    txn(0, 1'b0, 9'h034, 32'h0,        3'd2, 0, 1'b0, "t6_lw_resp");
    check_val("t6_lw_resp_value", rsp_rdata[0], 32'h87654321);

    for (int i = 0; i < 300; i++) begin
      random_txn(0);
      random_txn(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
